id_stage: RTL and testbench

- Instruction-decode stage of the RV32I pipeline. Sits between instruction fetch and execute, directly upstream of the register file's read ports and downstream of its write port.
- Decodes the fetched instruction and drives rs1/rs2 read addresses to the register file. Bypasses the same-cycle write-back value, generates immediates and control, and detects load-use hazards.
- Holds the ID/EX pipeline register, with a valid/ready handshake on both sides and a flush input.

---
 rtl/rv32_pkg.sv | 68 ++++++
 rtl/imm_gen.sv | 30 +++
 rtl/id_stage.sv | 199 +++++++++++++++++++
 tb/tb_id_stage.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation and immediate-format
// encodings, and the bundle of ID/EX control bits.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_COPY_B = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_t;

  // All-zero means "no side effects", which is what a bubble must carry.
  typedef struct packed {
    logic alu_src_imm;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic branch;
    logic jump;
    logic jalr;
    logic pc_src_a;
    logic illegal;
  } ctrl_t;

  // funct3/funct7[5] to ALU op; the funct7 bit only selects SUB for OP and
  // SRA for shifts, so addi with imm[10] set stays an ADD.
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic f7b5,
                                         input logic is_op);
    case (f3)
      3'd0:    alu_decode = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1:    alu_decode = ALU_SLL;
      3'd2:    alu_decode = ALU_SLT;
      3'd3:    alu_decode = ALU_SLTU;
      3'd4:    alu_decode = ALU_XOR;
      3'd5:    alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
      3'd6:    alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; every format is sign-extended to XLEN.
module imm_gen
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  imm_type_t       imm_type_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type_i)
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register-file addressing with write-back bypass, decode,
// load-use stall and the ID/EX pipeline register with valid/ready handshake.
module id_stage
  import rv32_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_valid,
  input  logic [XLEN-1:0]   i_if_pc,
  input  logic [31:0]       i_if_instr,
  output logic              o_id_ready,
  output logic [REG_AW-1:0] o_read_rs1,
  output logic [REG_AW-1:0] o_read_rs2,
  input  logic [XLEN-1:0]   i_rs1_data,
  input  logic [XLEN-1:0]   i_rs2_data,
  input  logic              i_wb_reg_write,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [XLEN-1:0]   i_wb_data,
  input  logic              i_flush,
  input  logic              i_ex_ready,
  output logic              o_ex_valid,
  output logic [XLEN-1:0]   o_ex_pc,
  output logic [XLEN-1:0]   o_ex_rs1_data,
  output logic [XLEN-1:0]   o_ex_rs2_data,
  output logic [XLEN-1:0]   o_ex_imm,
  output logic [REG_AW-1:0] o_ex_rs1,
  output logic [REG_AW-1:0] o_ex_rs2,
  output logic [REG_AW-1:0] o_ex_rd,
  output logic [3:0]        o_ex_alu_op,
  output logic [2:0]        o_ex_funct3,
  output logic              o_ex_alu_src_imm,
  output logic              o_ex_mem_read,
  output logic              o_ex_mem_write,
  output logic              o_ex_reg_write,
  output logic              o_ex_branch,
  output logic              o_ex_jump,
  output logic              o_ex_jalr,
  output logic              o_ex_pc_src_a,
  output logic              o_ex_illegal
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   imm_raw, rs1_fwd, rs2_fwd;

  ctrl_t     ctrl;
  alu_op_t   alu_op;
  imm_type_t imm_type;
  logic      uses_rs1, uses_rs2, has_rd, has_imm;
  logic      adv, load_use;

  logic              valid_q;
  logic [XLEN-1:0]   pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  alu_op_t           alu_op_q;
  logic [2:0]        funct3_q;
  ctrl_t             ctrl_q;

  assign opcode = i_if_instr[6:0];
  assign funct3 = i_if_instr[14:12];
  assign rs1    = REG_AW'(i_if_instr[19:15]);
  assign rs2    = REG_AW'(i_if_instr[24:20]);
  assign rd     = REG_AW'(i_if_instr[11:7]);

  assign o_read_rs1 = rs1;
  assign o_read_rs2 = rs2;

  // Opcode constants all end in 2'b11, so compressed encodings fall to illegal.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ctrl     = '0;
    alu_op   = ALU_ADD;
    imm_type = IMM_I;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    has_rd   = 1'b0;
    has_imm  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm_type = IMM_U; has_imm = 1'b1; has_rd = 1'b1;
        ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; alu_op = ALU_COPY_B;
      end
      OPC_AUIPC: begin
        imm_type = IMM_U; has_imm = 1'b1; has_rd = 1'b1;
        ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.pc_src_a = 1'b1;
      end
      OPC_JAL: begin
        imm_type = IMM_J; has_imm = 1'b1; has_rd = 1'b1;
        ctrl.jump = 1'b1; ctrl.reg_write = 1'b1;
      end
      OPC_JALR: begin
        imm_type = IMM_I; has_imm = 1'b1; has_rd = 1'b1; uses_rs1 = 1'b1;
        ctrl.jump = 1'b1; ctrl.jalr = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1;
      end
      OPC_BRANCH: begin
        if (funct3 == 3'd2 || funct3 == 3'd3) begin
          ctrl.illegal = 1'b1;
        end else begin
          imm_type = IMM_B; has_imm = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
          ctrl.branch = 1'b1;
        end
      end
      OPC_LOAD: begin
        imm_type = IMM_I; has_imm = 1'b1; has_rd = 1'b1; uses_rs1 = 1'b1;
        ctrl.mem_read = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1;
      end
      OPC_STORE: begin
        imm_type = IMM_S; has_imm = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ctrl.mem_write = 1'b1; ctrl.alu_src_imm = 1'b1;
      end
      OPC_OPIMM: begin
        imm_type = IMM_I; has_imm = 1'b1; has_rd = 1'b1; uses_rs1 = 1'b1;
        ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1;
        alu_op = alu_decode(funct3, i_if_instr[30], 1'b0);
      end
      OPC_OP: begin
        has_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ctrl.reg_write = 1'b1;
        alu_op = alu_decode(funct3, i_if_instr[30], 1'b1);
      end
      OPC_MISCMEM: ;
      default: ctrl.illegal = 1'b1;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i    (i_if_instr),
    .imm_type_i (imm_type),
    .imm_o      (imm_raw)
  );

  // The register file writes and reads x-regs in the same cycle; pick up the
  // value being written so ID never sees the stale copy.
  assign rs1_fwd = (i_wb_reg_write && i_wb_rd != '0 && i_wb_rd == rs1) ? i_wb_data : i_rs1_data;
  assign rs2_fwd = (i_wb_reg_write && i_wb_rd != '0 && i_wb_rd == rs2) ? i_wb_data : i_rs2_data;

  assign adv      = !valid_q || i_ex_ready;
  assign load_use = valid_q && ctrl_q.mem_read && rd_q != '0 && i_if_valid &&
                    ((uses_rs1 && rd_q == rs1) || (uses_rs2 && rd_q == rs2));
  assign o_id_ready = i_flush || (adv && !load_use);

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      alu_op_q   <= ALU_ADD;
      funct3_q   <= '0;
      ctrl_q     <= '0;
    end else if (i_flush || (adv && load_use)) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (adv) begin
      valid_q    <= i_if_valid;
      pc_q       <= i_if_pc;
      rs1_data_q <= rs1_fwd;
      rs2_data_q <= rs2_fwd;
      imm_q      <= has_imm ? imm_raw : '0;
      rs1_q      <= uses_rs1 ? rs1 : '0;
      rs2_q      <= uses_rs2 ? rs2 : '0;
      rd_q       <= has_rd ? rd : '0;
      alu_op_q   <= alu_op;
      funct3_q   <= funct3;
      ctrl_q     <= ctrl;
    end
  end

  assign o_ex_valid       = valid_q;
  assign o_ex_pc          = pc_q;
  assign o_ex_rs1_data    = rs1_data_q;
  assign o_ex_rs2_data    = rs2_data_q;
  assign o_ex_imm         = imm_q;
  assign o_ex_rs1         = rs1_q;
  assign o_ex_rs2         = rs2_q;
  assign o_ex_rd          = rd_q;
  assign o_ex_alu_op      = alu_op_q;
  assign o_ex_funct3      = funct3_q;
  assign o_ex_alu_src_imm = ctrl_q.alu_src_imm;
  assign o_ex_mem_read    = ctrl_q.mem_read;
  assign o_ex_mem_write   = ctrl_q.mem_write;
  assign o_ex_reg_write   = ctrl_q.reg_write;
  assign o_ex_branch      = ctrl_q.branch;
  assign o_ex_jump        = ctrl_q.jump;
  assign o_ex_jalr        = ctrl_q.jalr;
  assign o_ex_pc_src_a    = ctrl_q.pc_src_a;
  assign o_ex_illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, bypass, load-use, back-pressure, flush,
// immediates and illegal-instruction decode against hand-computed values.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        id_ready;
  logic [4:0]  read_rs1, read_rs2;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  logic        ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_branch, ex_jump, ex_jalr, ex_pc_src_a, ex_illegal;
  logic [8:0]  ex_ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ex_ctrl = {ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write,
                    ex_branch, ex_jump, ex_jalr, ex_pc_src_a, ex_illegal};

  id_stage #(.XLEN(32), .REG_AW(5)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_if_valid       (if_valid),
    .i_if_pc          (if_pc),
    .i_if_instr       (if_instr),
    .o_id_ready       (id_ready),
    .o_read_rs1       (read_rs1),
    .o_read_rs2       (read_rs2),
    .i_rs1_data       (rs1_data),
    .i_rs2_data       (rs2_data),
    .i_wb_reg_write   (wb_reg_write),
    .i_wb_rd          (wb_rd),
    .i_wb_data        (wb_data),
    .i_flush          (flush),
    .i_ex_ready       (ex_ready),
    .o_ex_valid       (ex_valid),
    .o_ex_pc          (ex_pc),
    .o_ex_rs1_data    (ex_rs1_data),
    .o_ex_rs2_data    (ex_rs2_data),
    .o_ex_imm         (ex_imm),
    .o_ex_rs1         (ex_rs1),
    .o_ex_rs2         (ex_rs2),
    .o_ex_rd          (ex_rd),
    .o_ex_alu_op      (ex_alu_op),
    .o_ex_funct3      (ex_funct3),
    .o_ex_alu_src_imm (ex_alu_src_imm),
    .o_ex_mem_read    (ex_mem_read),
    .o_ex_mem_write   (ex_mem_write),
    .o_ex_reg_write   (ex_reg_write),
    .o_ex_branch      (ex_branch),
    .o_ex_jump        (ex_jump),
    .o_ex_jalr        (ex_jalr),
    .o_ex_pc_src_a    (ex_pc_src_a),
    .o_ex_illegal     (ex_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_valid = 1'b1; if_instr = 32'h0070_0293; if_pc = 32'h0000_0100;
    rs1_data = '0; rs2_data = '0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; ex_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ((|{ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_alu_op, ex_funct3, ex_ctrl}) !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b pc=%h imm=%h rd=%0d ctrl=%b, required all zero",
               ex_valid, ex_pc, ex_imm, ex_rd, ex_ctrl);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b required 1", id_ready);
    end
  endtask

  task automatic test_bypass();
    rs1_data = 32'h1111; rs2_data = 32'h2222;
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD;
    drive(32'h0070_0293, 32'h100);  // addi x5,x0,7
    tick();
    n_checks++;
    if ({ex_valid, ex_rd, ex_imm, ex_pc, ex_alu_src_imm} !== {1'b1, 5'd5, 32'd7, 32'h100, 1'b1}) begin
      n_fail++;
      $display("FAIL addi_decode: valid=%b rd=%0d imm=%h pc=%h src_imm=%b, required 1 5 7 100 1",
               ex_valid, ex_rd, ex_imm, ex_pc, ex_alu_src_imm);
    end
    n_checks++;
    if (ex_rs1_data !== 32'h1111) begin
      n_fail++; $display("FAIL addi_x0_no_bypass: got %h required 00001111", ex_rs1_data);
    end
    drive(32'h0052_8333, 32'h104);  // add x6,x5,x5
    n_checks++;
    if ({read_rs1, read_rs2} !== {5'd5, 5'd5}) begin
      n_fail++; $display("FAIL read_addr: got rs1=%0d rs2=%0d required 5 5", read_rs1, read_rs2);
    end
    tick();
    n_checks++;
    if ({ex_rs1_data, ex_rs2_data} !== {32'hDEAD, 32'hDEAD}) begin
      n_fail++; $display("FAIL bypass_data: got %h %h required 0000dead 0000dead", ex_rs1_data, ex_rs2_data);
    end
    n_checks++;
    if ({ex_alu_op, ex_rd, ex_rs1, ex_rs2, ex_reg_write, ex_alu_src_imm} !==
        {4'd0, 5'd6, 5'd5, 5'd5, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_decode: alu=%0d rd=%0d rs1=%0d rs2=%0d rw=%b src=%b, required 0 6 5 5 1 0",
               ex_alu_op, ex_rd, ex_rs1, ex_rs2, ex_reg_write, ex_alu_src_imm);
    end
    wb_reg_write = 1'b0;
    drive(32'h4052_83B3, 32'h108);  // sub x7,x5,x5 with no write-back
    tick();
    n_checks++;
    if ({ex_rs1_data, ex_rs2_data, ex_alu_op, ex_rd} !== {32'h1111, 32'h2222, 4'd1, 5'd7}) begin
      n_fail++;
      $display("FAIL sub_no_wb: rs1d=%h rs2d=%h alu=%0d rd=%0d, required 1111 2222 1 7",
               ex_rs1_data, ex_rs2_data, ex_alu_op, ex_rd);
    end
    wb_reg_write = 1'b1; wb_rd = 5'd0;
    drive(32'h0000_0433, 32'h10C);  // add x8,x0,x0 while wb targets x0
    tick();
    n_checks++;
    if ({ex_rs1_data, ex_rs2_data} !== {32'h1111, 32'h2222}) begin
      n_fail++; $display("FAIL bypass_x0: got %h %h required 1111 2222", ex_rs1_data, ex_rs2_data);
    end
    wb_reg_write = 1'b0;
  endtask

  task automatic test_load_use();
    drive(32'h0000_A283, 32'h200);  // lw x5,0(x1)
    tick();
    n_checks++;
    if ({ex_valid, ex_mem_read, ex_rd, ex_rs1} !== {1'b1, 1'b1, 5'd5, 5'd1}) begin
      n_fail++; $display("FAIL lw_decode: valid=%b mr=%b rd=%0d rs1=%0d, required 1 1 5 1",
                         ex_valid, ex_mem_read, ex_rd, ex_rs1);
    end
    drive(32'h0002_8333, 32'h204);  // add x6,x5,x0
    n_checks++;
    if (id_ready !== 1'b0) begin
      n_fail++; $display("FAIL load_use_stall: ready=%b required 0", id_ready);
    end
    tick();
    n_checks++;
    if ({ex_valid, ex_ctrl} !== 10'b0) begin
      n_fail++; $display("FAIL bubble: valid=%b ctrl=%b required 0 000000000", ex_valid, ex_ctrl);
    end
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++; $display("FAIL bubble_ready: ready=%b required 1", id_ready);
    end
    tick();
    n_checks++;
    if ({ex_valid, ex_rd, ex_rs1, ex_pc} !== {1'b1, 5'd6, 5'd5, 32'h204}) begin
      n_fail++; $display("FAIL add_after_bubble: valid=%b rd=%0d rs1=%0d pc=%h, required 1 6 5 204",
                         ex_valid, ex_rd, ex_rs1, ex_pc);
    end
    drive(32'h0000_A283, 32'h208);  // lw x5,0(x1)
    tick();
    drive(32'h1234_52B7, 32'h20C);  // lui x5,0x12345
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++; $display("FAIL lui_no_stall: ready=%b required 1", id_ready);
    end
    tick();
    n_checks++;
    if ({ex_valid, ex_imm, ex_alu_op, ex_rd, ex_rs1, ex_reg_write} !==
        {1'b1, 32'h1234_5000, 4'd10, 5'd5, 5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL lui_decode: valid=%b imm=%h alu=%0d rd=%0d rs1=%0d rw=%b, required 1 12345000 10 5 0 1",
               ex_valid, ex_imm, ex_alu_op, ex_rd, ex_rs1, ex_reg_write);
    end
  endtask

  task automatic test_back_pressure();
    ex_ready = 1'b0;
    drive(32'h0010_0093, 32'h300);  // addi x1,x0,1
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (id_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready cycle %0d: ready=%b required 0", i, id_ready);
      end
      tick();
      n_checks++;
      if ({ex_valid, ex_imm, ex_rd, ex_pc} !== {1'b1, 32'h1234_5000, 5'd5, 32'h20C}) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: valid=%b imm=%h rd=%0d pc=%h, required 1 12345000 5 20c",
                           i, ex_valid, ex_imm, ex_rd, ex_pc);
      end
    end
    ex_ready = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: ready=%b required 1", id_ready);
    end
    tick();
    n_checks++;
    if ({ex_valid, ex_rd, ex_imm, ex_pc} !== {1'b1, 5'd1, 32'd1, 32'h300}) begin
      n_fail++; $display("FAIL bp_advance: valid=%b rd=%0d imm=%h pc=%h, required 1 1 1 300",
                         ex_valid, ex_rd, ex_imm, ex_pc);
    end
  endtask

  task automatic test_flush();
    drive(32'h0000_A283, 32'h400);  // lw x5,0(x1)
    tick();
    ex_ready = 1'b0;
    drive(32'h0002_8333, 32'h404);  // add x6,x5,x0: load-use plus EX stall
    n_checks++;
    if (id_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_pre_ready: ready=%b required 0", id_ready);
    end
    flush = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_ready: ready=%b required 1", id_ready);
    end
    tick();
    n_checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000) begin
      n_fail++; $display("FAIL flush_kill: valid=%b rw=%b mr=%b required 0 0 0",
                         ex_valid, ex_reg_write, ex_mem_read);
    end
    flush = 1'b0;
    ex_ready = 1'b1;
  endtask

  task automatic test_imm_illegal();
    drive(32'hFE00_0EE3, 32'h500);  // beq x0,x0,-4
    tick();
    n_checks++;
    if ({ex_imm, ex_branch, ex_reg_write, ex_rd} !== {32'hFFFF_FFFC, 1'b1, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL beq_imm: imm=%h br=%b rw=%b rd=%0d, required fffffffc 1 0 0",
                         ex_imm, ex_branch, ex_reg_write, ex_rd);
    end
    drive(32'h0010_00EF, 32'h504);  // jal x1,+2048
    tick();
    n_checks++;
    if ({ex_imm, ex_jump, ex_reg_write, ex_rd, ex_jalr} !== {32'h0000_0800, 1'b1, 1'b1, 5'd1, 1'b0}) begin
      n_fail++; $display("FAIL jal_imm: imm=%h j=%b rw=%b rd=%0d jalr=%b, required 00000800 1 1 1 0",
                         ex_imm, ex_jump, ex_reg_write, ex_rd, ex_jalr);
    end
    drive(32'hFE20_AC23, 32'h508);  // sw x2,-8(x1)
    tick();
    n_checks++;
    if ({ex_imm, ex_mem_write, ex_reg_write, ex_rd, ex_rs1, ex_rs2} !==
        {32'hFFFF_FFF8, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2}) begin
      n_fail++; $display("FAIL sw_imm: imm=%h mw=%b rw=%b rd=%0d rs1=%0d rs2=%0d, required fffffff8 1 0 0 1 2",
                         ex_imm, ex_mem_write, ex_reg_write, ex_rd, ex_rs1, ex_rs2);
    end
    drive(32'h4040_D193, 32'h50C);  // srai x3,x1,4
    tick();
    n_checks++;
    if ({ex_alu_op, ex_imm, ex_funct3, ex_rs2} !== {4'd7, 32'h0000_0404, 3'd5, 5'd0}) begin
      n_fail++; $display("FAIL srai: alu=%0d imm=%h f3=%0d rs2=%0d, required 7 00000404 5 0",
                         ex_alu_op, ex_imm, ex_funct3, ex_rs2);
    end
    drive(32'h4000_8193, 32'h510);  // addi x3,x1,0x400: funct7[5] ignored
    tick();
    n_checks++;
    if ({ex_alu_op, ex_imm} !== {4'd0, 32'h0000_0400}) begin
      n_fail++; $display("FAIL addi_bit30: alu=%0d imm=%h, required 0 00000400", ex_alu_op, ex_imm);
    end
    drive(32'h0000_0073, 32'h514);  // ecall -> SYSTEM is illegal
    tick();
    n_checks++;
    if ({ex_valid, ex_illegal, ex_reg_write, ex_ctrl[8:1]} !== {1'b1, 1'b1, 1'b0, 8'b0}) begin
      n_fail++; $display("FAIL system_illegal: valid=%b ill=%b rw=%b ctrl=%b, required 1 1 0 000000001",
                         ex_valid, ex_illegal, ex_reg_write, ex_ctrl);
    end
    drive(32'h0000_2063, 32'h518);  // branch funct3=2
    tick();
    n_checks++;
    if ({ex_valid, ex_ctrl} !== {1'b1, 9'b0_0000_0001}) begin
      n_fail++; $display("FAIL branch_f3_illegal: valid=%b ctrl=%b, required 1 000000001", ex_valid, ex_ctrl);
    end
    drive(32'h0000_0010, 32'h51C);  // instr[1:0] != 2'b11
    tick();
    n_checks++;
    if ({ex_valid, ex_ctrl} !== {1'b1, 9'b0_0000_0001}) begin
      n_fail++; $display("FAIL compressed_illegal: valid=%b ctrl=%b, required 1 000000001", ex_valid, ex_ctrl);
    end
    drive(32'h0000_000F, 32'h520);  // fence -> valid NOP
    tick();
    n_checks++;
    if ({ex_valid, ex_ctrl, ex_rd} !== {1'b1, 9'b0, 5'd0}) begin
      n_fail++; $display("FAIL fence_nop: valid=%b ctrl=%b rd=%0d, required 1 000000000 0",
                         ex_valid, ex_ctrl, ex_rd);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_back_pressure();
    test_flush();
    test_imm_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
